// File: rtl/ccd_timing_pkg.sv
// ---------------------------------------------------------------------------
// ccd_timing_pkg
// Shared definitions for the linear-CCD timing generator:
//   - ccd_state_e : frame sequencer states (3-bit, fixed encoding so the
//                   state value seen on a debug probe stays stable)
//   - CTRL_*      : bit positions inside the cfg_ctrl register
//   - eff_div()   : clock divider value with zero treated as one
// ---------------------------------------------------------------------------
package ccd_timing_pkg;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_ICG_LOW   = 3'd1,
      ST_SH_HI     = 3'd2,
      ST_ICG_TRAIL = 3'd3,
      ST_READOUT   = 3'd4,
      ST_WAIT_INT  = 3'd5,
      ST_DONE      = 3'd6
   } ccd_state_e;

   localparam int CTRL_EN    = 0;
   localparam int CTRL_START = 1;
   localparam int CTRL_CONT  = 2;

   // A divider setting of 0 would never produce a tick; run it as 1.
   function automatic logic [31:0] eff_div(input logic [31:0] d);
      return (d == 32'd0) ? 32'd1 : d;
   endfunction

endpackage

// File: rtl/ccd_clk_div.sv
// ---------------------------------------------------------------------------
// ccd_clk_div
// Free-running tick generator and phiM toggle flop.
//   clk, rst_n : clock, asynchronous active-low reset
//   en         : run enable; low clears the counter and parks phim at 0
//   div        : phiM half-period in clk cycles (0 behaves as 1), re-read
//                on every cycle so a new value takes effect on the next wrap
//   tick       : one-cycle pulse when the counter reaches its last count
//   phim       : CCD master clock, toggles on each tick
// ---------------------------------------------------------------------------
module ccd_clk_div
   import ccd_timing_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        en,
   input  logic [31:0] div,
   output logic        tick,
   output logic        phim
);

   logic [31:0] div_cnt;
   logic [31:0] last_cnt;

   assign last_cnt = eff_div(div) - 32'd1;

   // '>=' rather than '==' so a divider shrunk mid-count wraps at once
   // instead of running the counter around through 2^32.
   assign tick = en && (div_cnt >= last_cnt);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         div_cnt <= '0;
         phim    <= 1'b0;
      end else if (!en) begin
         div_cnt <= '0;
         phim    <= 1'b0;
      end else if (tick) begin
         div_cnt <= '0;
         phim    <= ~phim;
      end else begin
         div_cnt <= div_cnt + 32'd1;
      end
   end

endmodule

// File: rtl/ccd_timing_gen.sv
// ---------------------------------------------------------------------------
// ccd_timing_gen
// Linear-CCD drive waveform generator fed by the CCD_driver register bank.
//   ACLK, ARESETN  : system clock, asynchronous active-low reset
//   cfg_ctrl       : [0] enable, [1] start (rising edge), [2] continuous
//   cfg_int_time   : integration wait after readout, in ticks
//   cfg_pix_cnt    : pixels per frame ([PIX_W-1:0] used)
//   cfg_clk_div    : phiM half-period in ACLK cycles
//   ccd_phim       : CCD master clock
//   ccd_sh         : shift gate
//   ccd_icg        : integration clear gate (idle high)
//   adc_strobe     : one-ACLK pulse per pixel; pix_idx is valid while high
//   pix_idx        : index of the pixel being strobed
//   busy           : sequencer not in IDLE
//   frame_done     : one-ACLK pulse at the end of each completed frame
//   frame_cnt      : completed-frame counter, present only when
//                    CCD_TIMING_FRAME_CNT_EN is defined
// A "tick" is one phiM half-period; all sequencer durations count ticks.
// int_time and pix_cnt are captured at frame start, so register writes
// during a frame apply from the next frame on. Dropping enable in any
// active state returns to IDLE on the next ACLK without a frame_done.
// ---------------------------------------------------------------------------
module ccd_timing_gen
   import ccd_timing_pkg::*;
#(
   parameter int PIX_W         = 12,
   parameter int ICG_LEAD      = 2,
   parameter int SH_WIDTH      = 4,
   parameter int ICG_TRAIL     = 6,
   parameter int TICKS_PER_PIX = 8
) (
   input  logic             ACLK,
   input  logic             ARESETN,
   input  logic [31:0]      cfg_ctrl,
   input  logic [31:0]      cfg_int_time,
   input  logic [31:0]      cfg_pix_cnt,
   input  logic [31:0]      cfg_clk_div,
   output logic             ccd_phim,
   output logic             ccd_sh,
   output logic             ccd_icg,
   output logic             adc_strobe,
   output logic [PIX_W-1:0] pix_idx,
   output logic             busy,
   output logic             frame_done
`ifdef CCD_TIMING_FRAME_CNT_EN
   ,
   output logic [15:0]      frame_cnt
`endif
);

   localparam logic [PIX_W-1:0] PIX_ONE = PIX_W'(1);

   ccd_state_e       state;
   logic             en;
   logic             cont;
   logic             start_q;
   logic             start_edge;
   logic             tick;
   logic [31:0]      tick_cnt;
   logic [31:0]      span;
   logic             span_end;
   logic [31:0]      int_sh;
   logic [PIX_W-1:0] pix_sh;
   logic             unused_cfg;

   assign en         = cfg_ctrl[CTRL_EN];
   assign cont       = cfg_ctrl[CTRL_CONT];
   assign start_edge = cfg_ctrl[CTRL_START] & ~start_q;
   assign unused_cfg = ^{cfg_ctrl[31:3], cfg_pix_cnt[31:PIX_W]};

   ccd_clk_div u_clk_div (
      .clk   (ACLK),
      .rst_n (ARESETN),
      .en    (en),
      .div   (cfg_clk_div),
      .tick  (tick),
      .phim  (ccd_phim)
   );

   // Length of the current state in ticks. In READOUT this is the pixel
   // period, so span_end marks each pixel boundary.
   always_comb begin
      span = 32'd1;
      case (state)
         ST_ICG_LOW:   span = 32'(ICG_LEAD);
         ST_SH_HI:     span = 32'(SH_WIDTH);
         ST_ICG_TRAIL: span = 32'(ICG_TRAIL);
         ST_READOUT:   span = 32'(TICKS_PER_PIX);
         ST_WAIT_INT:  span = int_sh;
         default:      span = 32'd1;
      endcase
   end

   // '>=' keeps the comparison safe if the counter ever overshoots.
   assign span_end = tick && (tick_cnt >= span - 32'd1);

   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         state      <= ST_IDLE;
         start_q    <= 1'b0;
         tick_cnt   <= '0;
         int_sh     <= '0;
         pix_sh     <= '0;
         adc_strobe <= 1'b0;
         pix_idx    <= '0;
      end else begin
         start_q    <= cfg_ctrl[CTRL_START];
         adc_strobe <= 1'b0;

         // The index advances in the cycle after its strobe; once the
         // sequencer has left READOUT it returns to 0 instead.
         if (adc_strobe)
            pix_idx <= (state == ST_READOUT) ? pix_idx + PIX_ONE : '0;

         // Tick counter restarts at every span boundary and saturates.
         if (tick && (state != ST_IDLE)) begin
            if (span_end)
               tick_cnt <= '0;
            else if (tick_cnt != '1)
               tick_cnt <= tick_cnt + 32'd1;
         end

         if ((state != ST_IDLE) && !en) begin
            state    <= ST_IDLE;
            tick_cnt <= '0;
            pix_idx  <= '0;
         end else begin
            case (state)
               ST_IDLE: begin
                  if (en && start_edge) begin
                     int_sh   <= cfg_int_time;
                     pix_sh   <= cfg_pix_cnt[PIX_W-1:0];
                     tick_cnt <= '0;
                     state    <= ST_ICG_LOW;
                  end
               end
               ST_ICG_LOW: begin
                  if (span_end)
                     state <= ST_SH_HI;
               end
               ST_SH_HI: begin
                  if (span_end)
                     state <= ST_ICG_TRAIL;
               end
               ST_ICG_TRAIL: begin
                  if (span_end)
                     state <= (pix_sh == '0) ? ST_WAIT_INT : ST_READOUT;
               end
               ST_READOUT: begin
                  if (span_end) begin
                     adc_strobe <= 1'b1;
                     if (pix_idx >= pix_sh - PIX_ONE)
                        state <= ST_WAIT_INT;
                  end
               end
               ST_WAIT_INT: begin
                  if (int_sh == '0) begin
                     tick_cnt <= '0;
                     state    <= ST_DONE;
                  end else if (span_end) begin
                     state <= ST_DONE;
                  end
               end
               ST_DONE: begin
                  tick_cnt <= '0;
                  if (cont) begin
                     int_sh <= cfg_int_time;
                     pix_sh <= cfg_pix_cnt[PIX_W-1:0];
                     state  <= ST_ICG_LOW;
                  end else begin
                     state <= ST_IDLE;
                  end
               end
               default: begin
                  tick_cnt <= '0;
                  state    <= ST_IDLE;
               end
            endcase
         end
      end
   end

   // Gate levels decode directly from the registered state.
   assign busy       = (state != ST_IDLE);
   assign ccd_sh     = (state == ST_SH_HI);
   assign ccd_icg    = !((state == ST_ICG_LOW) || (state == ST_SH_HI) ||
                         (state == ST_ICG_TRAIL));
   assign frame_done = (state == ST_DONE);

`ifdef CCD_TIMING_FRAME_CNT_EN
   logic en_q;

   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         en_q      <= 1'b0;
         frame_cnt <= '0;
      end else begin
         en_q <= en;
         if (en_q && !en)
            frame_cnt <= '0;
         else if (frame_done)
            frame_cnt <= frame_cnt + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_ccd_timing_gen.sv
// ---------------------------------------------------------------------------
// tb_ccd_timing_gen
// Self-checking bench for ccd_timing_gen. A negedge monitor logs the cycle
// number of every waveform edge, strobe and frame_done; the expected
// timing of each frame is then computed from the waveform rules with plain
// arithmetic (tick = max(div,1) cycles) and compared against those logs.
// Define CCD_TIMING_FRAME_CNT_EN to also exercise frame_cnt.
// ---------------------------------------------------------------------------
module tb_ccd_timing_gen;

   localparam int PIX_W = 12;

   logic             ACLK = 1'b0;
   logic             ARESETN = 1'b0;
   logic [31:0]      cfg_ctrl = '0;
   logic [31:0]      cfg_int_time = '0;
   logic [31:0]      cfg_pix_cnt = '0;
   logic [31:0]      cfg_clk_div = '0;
   logic             ccd_phim, ccd_sh, ccd_icg, adc_strobe, busy, frame_done;
   logic [PIX_W-1:0] pix_idx;
`ifdef CCD_TIMING_FRAME_CNT_EN
   logic [15:0]      frame_cnt;
`endif

   ccd_timing_gen dut (
      .ACLK         (ACLK),
      .ARESETN      (ARESETN),
      .cfg_ctrl     (cfg_ctrl),
      .cfg_int_time (cfg_int_time),
      .cfg_pix_cnt  (cfg_pix_cnt),
      .cfg_clk_div  (cfg_clk_div),
      .ccd_phim     (ccd_phim),
      .ccd_sh       (ccd_sh),
      .ccd_icg      (ccd_icg),
      .adc_strobe   (adc_strobe),
      .pix_idx      (pix_idx),
      .busy         (busy),
      .frame_done   (frame_done)
`ifdef CCD_TIMING_FRAME_CNT_EN
      ,
      .frame_cnt    (frame_cnt)
`endif
   );

   // ---------------- clock / reset ----------------
   always #5 ACLK = ~ACLK;

   int unsigned cyc = 0;
   always @(posedge ACLK) cyc <= cyc + 1;

   // ---------------- event monitor ----------------
   int unsigned      icg_fall_q[$], icg_rise_q[$], sh_rise_q[$], sh_fall_q[$];
   int unsigned      phim_q[$], stb_t_q[$], done_q[$];
   logic [PIX_W-1:0] stb_idx_q[$];
   logic             p_icg = 1'b1, p_sh = 1'b0, p_phim = 1'b0;

   always @(negedge ACLK) begin
      if (ARESETN) begin
         if (p_icg && !ccd_icg) icg_fall_q.push_back(cyc);
         if (!p_icg && ccd_icg) icg_rise_q.push_back(cyc);
         if (!p_sh && ccd_sh)   sh_rise_q.push_back(cyc);
         if (p_sh && !ccd_sh)   sh_fall_q.push_back(cyc);
         if (p_phim != ccd_phim) phim_q.push_back(cyc);
         if (adc_strobe) begin
            stb_t_q.push_back(cyc);
            stb_idx_q.push_back(pix_idx);
         end
         if (frame_done) done_q.push_back(cyc);
      end
      p_icg  = ccd_icg;
      p_sh   = ccd_sh;
      p_phim = ccd_phim;
   end

   // ---------------- scoreboard / checking ----------------
   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
   endtask

   task automatic clear_logs();
      icg_fall_q.delete(); icg_rise_q.delete();
      sh_rise_q.delete();  sh_fall_q.delete();
      phim_q.delete();     stb_t_q.delete();
      stb_idx_q.delete();  done_q.delete();
   endtask

   // ---------------- driver tasks ----------------
   task automatic step(input int n);
      repeat (n) @(negedge ACLK);
   endtask

   // Program the registers, let the divider settle, then raise start.
   task automatic start_frame(input int d, input int p, input int n,
                              input bit cont);
      cfg_clk_div  = d;
      cfg_pix_cnt  = p;
      cfg_int_time = n;
      cfg_ctrl     = {29'd0, cont, 1'b0, 1'b1};
      step(8);
      clear_logs();
      cfg_ctrl[1]  = 1'b1;
      step(1);
   endtask

   task automatic wait_idle(input string tag, input int budget);
      int  k;
      bit  expired;
      k = 0;
      while (busy && k < budget) begin
         step(1);
         k++;
      end
      expired = busy;
      check(tag, expired, 1'b0);
   endtask

   // Reference timing of one frame, measured from ICG rising (r):
   //   SH high = 4 ticks, SH fall -> ICG rise = 6 ticks,
   //   ICG fall -> SH rise lies in ((2-1) ticks, 2 ticks],
   //   strobe k at r + 8*T*(k+1) with index k,
   //   frame_done at r + 8*T*P + (N ? N*T : 1).
   task automatic check_frame(input string tag, input int d, input int p,
                              input int n);
      int unsigned t, lead, r, exp_done, bad;
      t = (d == 0) ? 1 : d;
      check({tag, " n_icg_rise"}, icg_rise_q.size(), 1);
      check({tag, " n_sh_rise"}, sh_rise_q.size(), 1);
      if (icg_rise_q.size() == 1 && sh_rise_q.size() == 1 &&
          sh_fall_q.size() == 1 && icg_fall_q.size() == 1) begin
         r = icg_rise_q[0];
         check({tag, " sh_width"}, sh_fall_q[0] - sh_rise_q[0], 4 * t);
         check({tag, " icg_trail"}, icg_rise_q[0] - sh_fall_q[0], 6 * t);
         lead = sh_rise_q[0] - icg_fall_q[0];
         check({tag, " icg_lead_in_range"},
               (lead >= t + 1 && lead <= 2 * t), 1'b1);
         check({tag, " n_strobe"}, stb_t_q.size(), p);
         if (stb_t_q.size() == p) begin
            for (int k = 0; k < p; k++) begin
               check({tag, " strobe_time"}, stb_t_q[k] - r, 8 * t * (k + 1));
               check({tag, " strobe_idx"}, 32'(stb_idx_q[k]), k);
            end
         end
         exp_done = 8 * t * p + ((n > 0) ? n * t : 1);
         check({tag, " n_done"}, done_q.size(), 1);
         if (done_q.size() == 1)
            check({tag, " done_time"}, done_q[0] - r, exp_done);
         bad = 0;
         for (int k = 1; k < phim_q.size(); k++)
            if (phim_q[k-1] >= icg_fall_q[0] && phim_q[k] - phim_q[k-1] != t)
               bad++;
         check({tag, " phim_half_period_errors"}, bad, 0);
      end
      check({tag, " pix_idx_after"}, 32'(pix_idx), 0);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int d, p, n;
      int unsigned t, k;
      bit expired;

      // Reset values
      step(3);
      check("rst phim", ccd_phim, 0);
      check("rst sh", ccd_sh, 0);
      check("rst icg", ccd_icg, 1);
      check("rst strobe", adc_strobe, 0);
      check("rst pix_idx", 32'(pix_idx), 0);
      check("rst busy", busy, 0);
      check("rst done", frame_done, 0);
`ifdef CCD_TIMING_FRAME_CNT_EN
      check("rst frame_cnt", 32'(frame_cnt), 0);
`endif
      ARESETN = 1'b1;
      step(2);

      // Directed single frame
      start_frame(2, 4, 0, 1'b0);
      check("single busy", busy, 1);
      wait_idle("single timeout", 20000);
      step(4);
      check_frame("single", 2, 4, 0);

      // Edge cases: pix_cnt = 0, div = 0
      start_frame(1, 0, 0, 1'b0);
      wait_idle("pix0 timeout", 20000);
      step(4);
      check_frame("pix0", 1, 0, 0);
      start_frame(0, 2, 3, 1'b0);
      wait_idle("div0 timeout", 20000);
      step(4);
      check_frame("div0", 0, 2, 3);

      // Randomized frames
      for (int i = 0; i < 6; i++) begin
         d = $urandom_range(0, 4);
         p = $urandom_range(0, 5);
         n = $urandom_range(0, 12);
         start_frame(d, p, n, 1'b0);
         wait_idle("rand timeout", 20000);
         step(4);
         check_frame("rand", d, p, n);
      end

      // Mid-frame register writes must not affect the running frame
      start_frame(2, 3, 4, 1'b0);
      step(5);
      cfg_pix_cnt  = 9;
      cfg_int_time = 100;
      wait_idle("midwrite timeout", 20000);
      step(4);
      check_frame("midwrite", 2, 3, 4);

      // Start edge while busy is ignored
      start_frame(1, 2, 20, 1'b0);
      step(20);
      for (int i = 0; i < 2; i++) begin
         cfg_ctrl[1] = 1'b0; step(2);
         cfg_ctrl[1] = 1'b1; step(2);
      end
      wait_idle("busystart timeout", 20000);
      step(50);
      check("busystart n_done", done_q.size(), 1);
      check("busystart n_strobe", stb_t_q.size(), 2);
      check("busystart idle", busy, 0);

      // Continuous mode: 3 back-to-back frames, then stop after the 4th
      d = $urandom_range(1, 3);
      t = d;
      start_frame(d, 3, 10, 1'b1);
      k = 0;
      while (done_q.size() < 3 && k < 20000) begin
         step(1);
         k++;
      end
      expired = (done_q.size() < 3);
      check("cont timeout", expired, 1'b0);
      step(5);
      cfg_ctrl[2] = 1'b0;
      wait_idle("cont stop timeout", 20000);
      step(20);
      check("cont n_done", done_q.size(), 4);
      check("cont n_strobe", stb_t_q.size(), 12);
      if (done_q.size() == 4 && icg_rise_q.size() == 4 &&
          icg_fall_q.size() == 4) begin
         check("cont spacing 1", done_q[2] - done_q[1], done_q[1] - done_q[0]);
         check("cont spacing 2", done_q[3] - done_q[2], done_q[1] - done_q[0]);
         for (int i = 0; i < 4; i++)
            check("cont done_time", done_q[i] - icg_rise_q[i],
                  8 * t * 3 + 10 * t);
         for (int i = 0; i < 3; i++)
            check("cont restart", icg_fall_q[i+1] - done_q[i], 1);
      end

      // Abort mid-READOUT at pix_idx = 2
      start_frame(1, 6, 0, 1'b0);
      k = 0;
      while (!(adc_strobe && pix_idx == 2) && k < 2000) begin
         step(1);
         k++;
      end
      expired = !(adc_strobe && pix_idx == 2);
      check("abort reach timeout", expired, 1'b0);
      cfg_ctrl = '0;
      step(1);
      check("abort busy", busy, 0);
      check("abort icg", ccd_icg, 1);
      check("abort sh", ccd_sh, 0);
      check("abort phim", ccd_phim, 0);
      check("abort strobe", adc_strobe, 0);
      check("abort pix_idx", 32'(pix_idx), 0);
      step(300);
      check("abort n_strobe", stb_t_q.size(), 3);
      check("abort n_done", done_q.size(), 0);

`ifdef CCD_TIMING_FRAME_CNT_EN
      // frame_cnt: cleared by the abort above, counts 3 frames, then wraps
      check("fcnt cleared", 32'(frame_cnt), 0);
      for (int i = 0; i < 3; i++) begin
         start_frame(1, 0, 0, 1'b0);
         wait_idle("fcnt timeout", 2000);
      end
      check("fcnt three", 32'(frame_cnt), 3);
      dut.frame_cnt = 16'hFFFF;
      start_frame(1, 0, 0, 1'b0);
      wait_idle("fcnt wrap timeout", 2000);
      check("fcnt wrap", 32'(frame_cnt), 0);
`endif

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/ccd_timing_gen.md
Name: ccd_timing_gen

Overview:
- Downstream consumer of the CCD_driver AXI4-Lite register bank; takes its four 32-bit registers (ctrl, integration time, pixel count, clock divider) as inputs.
- Generates the linear-CCD drive waveforms: master clock phiM, shift gate SH and integration clear gate ICG.
- Emits an ADC sample strobe with a pixel index, and a frame-done pulse for the capture path.

Parameters:
- PIX_W, 12, width of pixel index and effective pixel count.
- ICG_LEAD, 2, ticks ICG is low before SH rises.
- SH_WIDTH, 4, ticks SH is held high.
- ICG_TRAIL, 6, ticks from SH falling to ICG rising.
- TICKS_PER_PIX, 8, ticks per pixel (one pixel per 4 phiM periods).

Ports:
- ACLK  in  1  system clock.
- ARESETN  in  1  asynchronous active-low reset.
- cfg_ctrl  in  32  bit0 enable, bit1 start (rising edge), bit2 continuous.
- cfg_int_time  in  32  integration wait, in ticks.
- cfg_pix_cnt  in  32  pixels per frame; only [PIX_W-1:0] used.
- cfg_clk_div  in  32  phiM half-period, in ACLK cycles.
- ccd_phim  out  1  CCD master clock.
- ccd_sh  out  1  shift gate.
- ccd_icg  out  1  integration clear gate (idle high).
- adc_strobe  out  1  one-ACLK pulse per pixel.
- pix_idx  out  PIX_W  index of the pixel being strobed.
- busy  out  1  high when not in IDLE.
- frame_done  out  1  one-ACLK pulse at frame end.

Behaviour:
- Clock and reset: one clock, ACLK; reset is asynchronous and active-low, ARESETN.
- Reset values: ccd_phim=0, ccd_sh=0, ccd_icg=1, adc_strobe=0, pix_idx=0, busy=0, frame_done=0; state=IDLE.
- Divider:
  - div_cnt counts 0..D-1, where D = max(cfg_clk_div,1).
  - "tick" is a one-cycle pulse when div_cnt==D-1; ccd_phim toggles on each tick.
  - With enable=0, div_cnt is cleared and phiM is held 0.
  - D is re-read on every wrap, not shadowed.
- Start: cfg_ctrl[1] is registered; the rising edge is detected in IDLE with enable=1. On that edge, int_time and pix_cnt are latched into shadow registers. Register writes mid-frame take no effect until the next frame. A start edge while busy is ignored.
- FSM (all durations in ticks):
  - IDLE: icg=1, sh=0. Start edge -> ICG_LOW.
  - ICG_LOW: icg=0 for ICG_LEAD ticks -> SH_HI.
  - SH_HI: sh=1 for SH_WIDTH ticks -> ICG_TRAIL.
  - ICG_TRAIL: sh=0, icg=0 for ICG_TRAIL ticks; then icg=1 -> READOUT, or -> WAIT_INT if pix_cnt==0.
  - READOUT: a pixel tick counter wraps at TICKS_PER_PIX-1.
    - On each wrap tick, adc_strobe=1 for that ACLK cycle, with pix_idx = current index; the index increments after the strobe.
    - After pix_cnt strobes -> WAIT_INT; pix_idx returns to 0.
  - WAIT_INT: wait int_time ticks (0 means move on the next cycle) -> DONE.
  - DONE: frame_done=1 for one ACLK cycle. Then -> ICG_LOW if continuous && enable, else -> IDLE.
- Abort: enable falling in any non-IDLE state -> IDLE on the next ACLK. Outputs take their idle values and no frame_done is issued.
- Counters saturate-safe: the 32-bit tick counter compares with >= and is never allowed to wrap.
- busy = (state != IDLE).

Optional Feature:
- Macro: CCD_TIMING_FRAME_CNT_EN.
- When defined: adds output frame_cnt [15:0]. It increments on each frame_done, wraps at 0xFFFF->0, and resets to 0. It also clears when the enable bit falls.
- When undefined: the port and its logic are absent.

Decomposition:
- Package ccd_timing_pkg holds:
  - the state enum (IDLE, ICG_LOW, SH_HI, ICG_TRAIL, READOUT, WAIT_INT, DONE);
  - ctrl bit-index localparams CTRL_EN=0, CTRL_START=1, CTRL_CONT=2.
- One sub-module, ccd_clk_div: divider, tick pulse and phiM toggle.

Test Plan:
- Reset: hold ARESETN=0 -> all outputs at their reset values; icg=1, phim=0.
- Single frame: div=2, pix_cnt=4, int_time=0, start edge -> icg low 2 ticks, sh high 4 ticks, 4 strobes with pix_idx 0..3 spaced 16 ACLK apart, one frame_done, busy drops.
- Continuous: ctrl=0b111, pix_cnt=3, int_time=10 -> three frames back-to-back; frame_done spacing is constant; clearing ctrl bit2 ends the run after the current frame.
- Abort: enable cleared mid-READOUT at pix_idx=2 -> IDLE next cycle, icg=1, no further strobes, no frame_done.
- Edge cases: div=0 behaves as div=1; pix_cnt=0 gives no strobes and frame_done still fires; a start edge while busy is ignored.
- Option: with CCD_TIMING_FRAME_CNT_EN defined, 3 frames -> frame_cnt=3; preload to 0xFFFF and run a frame -> 0.
